// File: rtl/eqn_pipe_arb.sv
// eqn_pipe_arb: two-requester round-robin front end for the equation pipeline.
// Carries a valid/requester-id shadow alongside the pipe and freezes it on result backpressure.
module eqn_pipe_arb #(
    parameter int LAT   = 4,
    parameter int W_IN  = 8,
    parameter int W_OUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][W_IN-1:0]  req_a,
    input  logic [1:0][W_IN-1:0]  req_b,
    input  logic [1:0][W_IN-1:0]  req_c,
    output logic [W_IN-1:0]       pipe_a,
    output logic [W_IN-1:0]       pipe_b,
    output logic [W_IN-1:0]       pipe_c,
    output logic                  pipe_stall,
    input  logic [W_OUT-1:0]      pipe_e,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [W_OUT-1:0]      res_e,
    output logic                  res_id,
    output logic [15:0]           stall_cnt
);
    logic [LAT-1:0] vld;
    logic [LAT-1:0] tid;
    logic           last;
    logic           grant_any;
    logic           grant_idx;

    assign res_valid  = vld[LAT-1];
    assign res_id     = tid[LAT-1];
    assign res_e      = pipe_e;
    assign pipe_stall = res_valid & ~res_ready;

    // Under contention the requester not served last wins; otherwise the lone valid one.
    always_comb begin
        grant_any = |req_valid;
        grant_idx = (&req_valid) ? ~last : req_valid[1];
    end

    assign req_ready[0] = ~pipe_stall & grant_any & ~grant_idx;
    assign req_ready[1] = ~pipe_stall & grant_any &  grant_idx;

    assign pipe_a = grant_any ? req_a[grant_idx] : '0;
    assign pipe_b = grant_any ? req_b[grant_idx] : '0;
    assign pipe_c = grant_any ? req_c[grant_idx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld       <= '0;
            tid       <= '0;
            last      <= 1'b1;
            stall_cnt <= '0;
        end else if (pipe_stall) begin
            if (stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end else begin
            vld <= (vld << 1) | LAT'(grant_any);
            tid <= (tid << 1) | LAT'(grant_idx);
            if (grant_any)
                last <= grant_idx;
        end
    end
endmodule
